// File: rtl/cpu_wb_bridge_pkg.sv
// cpu_wb_bridge_pkg: shared types and constants for the CPU-to-Wishbone bridge.
//   state_e     - bridge FSM encoding (idle, read burst, write burst)
//   LEN_SINGLE  - request length code for a single longword
//   LEN_LINE    - request length code for a 4-longword line burst
//   ERR_FILL    - read data substituted for a beat that ended in error/timeout
//   beat_addr() - word address of a beat, wrapping inside the 16-byte line
package cpu_wb_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRd   = 2'd1,
      StWr   = 2'd2
   } state_e;

   localparam logic [2:0]  LEN_SINGLE = 3'd1;
   localparam logic [2:0]  LEN_LINE   = 3'd4;
   localparam logic [31:0] ERR_FILL   = 32'hFFFF_FFFF;

   // Line bursts keep the line base and wrap the low word index.
   function automatic logic [29:0] beat_addr(input logic [29:0] base,
                                             input logic        line,
                                             input logic [1:0]  idx);
      logic [1:0] low;
      low = base[1:0] + idx;
      return line ? {base[29:2], low} : base;
   endfunction

endpackage

// File: rtl/cpu_wb_bridge_sync_fifo4.sv
// sync_fifo4: 4-entry, 32-bit synchronous FIFO with simultaneous push/pop.
//   clk_i, rst_i - clock, synchronous active-high reset (flushes contents)
//   push_i       - write data_i; ignored when full unless popping the same cycle
//   data_i       - data to push
//   pop_i        - discard the head; ignored when empty
//   data_o       - current head (0 when empty after reset)
//   count_o      - number of stored entries, 0..4
module sync_fifo4 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic [31:0] data_i,
   input  logic        pop_i,
   output logic [31:0] data_o,
   output logic [2:0]  count_o
);

   logic [31:0] mem_q [4];
   logic [31:0] mem_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic        do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop_i && (count_q != 3'd0);
      // A full FIFO can still take a push when the head leaves in the same cycle.
      do_push  = push_i && ((count_q != 3'd4) || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/cpu_wb_bridge.sv
// cpu_wb_bridge: turns the 68040 bus-interface request/data stream into Wishbone B3
// classic master cycles. One request can be pending behind the active one; write and
// read data are buffered in 4-deep FIFOs; every beat has an acknowledge timeout.
//   clk_i, rst_i        - clock, synchronous active-high reset
//   req_*               - request pulse and attributes (len 1 or 4, mask, addr, we)
//   req_ready           - write FIFO and pending slot both empty
//   write_valid/_data   - write longword pulse, no backpressure
//   read_valid/_data    - read FIFO head; read_ack pops it
//   wb_*                - Wishbone classic master port
//   bus_err_o           - sticky: a beat ended in wb_err_i or timeout
//   proto_err_o         - sticky: request overrun or write FIFO overflow
module cpu_wb_bridge
   import cpu_wb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_len,
   input  logic [3:0]  req_mask,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic        write_valid,
   input  logic [31:0] write_data,
   output logic        read_valid,
   output logic [31:0] read_data,
   input  logic        read_ack,
   output logic [29:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        bus_err_o,
   output logic        proto_err_o
);

   localparam logic [7:0] TmoLimit  = 8'(TIMEOUT);
   localparam logic [2:0] LineBeats = 3'(LINE_WORDS);

   state_e      state_q, state_d;

   // Pending request slot
   logic        pend_q, pend_d;
   logic        pend_line_q, pend_line_d;
   logic [3:0]  pend_mask_q, pend_mask_d;
   logic [29:0] pend_addr_q, pend_addr_d;
   logic        pend_we_q, pend_we_d;

   // Active request
   logic        act_line_q, act_line_d;
   logic [3:0]  act_mask_q, act_mask_d;
   logic [29:0] act_addr_q, act_addr_d;
   logic [2:0]  beats_left_q, beats_left_d;
   logic [1:0]  beat_idx_q, beat_idx_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;

   // Registered bus outputs
   logic        cyc_q, cyc_d;
   logic        stb_q, stb_d;
   logic [29:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic        bus_err_q, bus_err_d;
   logic        proto_err_q, proto_err_d;

   // FIFO interfaces
   logic        wf_push, wf_pop;
   logic [31:0] wf_head;
   logic [2:0]  wf_count;
   logic        rf_push, rf_pop;
   logic [31:0] rf_push_data;
   logic [31:0] rf_head;
   logic [2:0]  rf_count;

   logic        beat_term;
   logic        can_start;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^req_addr[1:0];

   assign wf_push = write_valid && (wf_count != 3'd4);
   assign rf_pop  = read_ack && (rf_count != 3'd0);

   // ack/err are only meaningful while stb is high; the timeout is checked last.
   assign beat_term = stb_q && (wb_ack_i || wb_err_i || (tmo_cnt_q == TmoLimit));

   // Reads wait for read FIFO room so no returned word is ever lost.
   assign can_start = (state_q == StRd) ? (rf_count != 3'd4) : (wf_count != 3'd0);

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      pend_line_d  = pend_line_q;
      pend_mask_d  = pend_mask_q;
      pend_addr_d  = pend_addr_q;
      pend_we_d    = pend_we_q;
      act_line_d   = act_line_q;
      act_mask_d   = act_mask_q;
      act_addr_d   = act_addr_q;
      beats_left_d = beats_left_q;
      beat_idx_d   = beat_idx_q;
      tmo_cnt_d    = tmo_cnt_q;
      cyc_d        = cyc_q;
      stb_d        = stb_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      we_d         = we_q;
      bus_err_d    = bus_err_q;
      proto_err_d  = proto_err_q;
      rf_push      = 1'b0;
      rf_push_data = wb_dat_i;
      wf_pop       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pend_q) begin
               act_line_d   = pend_line_q;
               act_mask_d   = pend_mask_q;
               act_addr_d   = pend_addr_q;
               beats_left_d = pend_line_q ? LineBeats : LEN_SINGLE;
               beat_idx_d   = 2'd0;
               pend_d       = 1'b0;
               state_d      = pend_we_q ? StWr : StRd;
            end
         end
         StRd, StWr: begin
            if (stb_q) begin
               if (beat_term) begin
                  stb_d        = 1'b0;
                  beats_left_d = beats_left_q - 3'd1;
                  beat_idx_d   = beat_idx_q + 2'd1;
                  if (state_q == StRd) begin
                     rf_push      = 1'b1;
                     rf_push_data = wb_ack_i ? wb_dat_i : ERR_FILL;
                  end else begin
                     wf_pop = 1'b1;
                  end
                  if (!wb_ack_i) begin
                     bus_err_d = 1'b1;
                  end
                  if (beats_left_q == 3'd1) begin
                     cyc_d   = 1'b0;
                     we_d    = 1'b0;
                     state_d = StIdle;
                  end
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end
            end else if (beats_left_q != 3'd0) begin
               // cyc is held across the inter-beat gap and while waiting for write data.
               cyc_d = 1'b1;
               if (can_start) begin
                  stb_d     = 1'b1;
                  tmo_cnt_d = 8'd0;
                  adr_d     = beat_addr(act_addr_q, act_line_q, beat_idx_q);
                  sel_d     = act_line_q ? 4'hF : act_mask_q;
                  we_d      = (state_q == StWr);
                  dat_d     = (state_q == StWr) ? wf_head : 32'd0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A new request is accepted only into an empty slot; otherwise it is lost.
      if (req_valid) begin
         if (pend_q) begin
            proto_err_d = 1'b1;
         end else begin
            pend_d      = 1'b1;
            pend_line_d = (req_len == LEN_LINE);
            pend_mask_d = req_mask;
            pend_addr_d = req_addr[31:2];
            pend_we_d   = req_we;
         end
      end
      if (write_valid && (wf_count == 3'd4)) begin
         proto_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         pend_q       <= 1'b0;
         pend_line_q  <= 1'b0;
         pend_mask_q  <= '0;
         pend_addr_q  <= '0;
         pend_we_q    <= 1'b0;
         act_line_q   <= 1'b0;
         act_mask_q   <= '0;
         act_addr_q   <= '0;
         beats_left_q <= '0;
         beat_idx_q   <= '0;
         tmo_cnt_q    <= '0;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         we_q         <= 1'b0;
         bus_err_q    <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         pend_line_q  <= pend_line_d;
         pend_mask_q  <= pend_mask_d;
         pend_addr_q  <= pend_addr_d;
         pend_we_q    <= pend_we_d;
         act_line_q   <= act_line_d;
         act_mask_q   <= act_mask_d;
         act_addr_q   <= act_addr_d;
         beats_left_q <= beats_left_d;
         beat_idx_q   <= beat_idx_d;
         tmo_cnt_q    <= tmo_cnt_d;
         cyc_q        <= cyc_d;
         stb_q        <= stb_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         bus_err_q    <= bus_err_d;
         proto_err_q  <= proto_err_d;
      end
   end

   sync_fifo4 u_wr_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (wf_push),
      .data_i  (write_data),
      .pop_i   (wf_pop),
      .data_o  (wf_head),
      .count_o (wf_count)
   );

   sync_fifo4 u_rd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rf_push),
      .data_i  (rf_push_data),
      .pop_i   (rf_pop),
      .data_o  (rf_head),
      .count_o (rf_count)
   );

   assign req_ready   = (wf_count == 3'd0) && !pend_q;
   assign read_valid  = (rf_count != 3'd0);
   assign read_data   = rf_head;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign wb_sel_o    = sel_q;
   assign wb_we_o     = we_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign bus_err_o   = bus_err_q;
   assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// tb_cpu_wb_bridge: directed self-checking bench for cpu_wb_bridge (TIMEOUT = 8).
// A behavioural Wishbone slave acks after slv_wait stb cycles (or never when slv_dead)
// and logs every acknowledged beat for the scenario tasks to check.
module tb_cpu_wb_bridge;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_len;
   logic [3:0]  req_mask;
   logic [31:0] req_addr;
   logic        write_valid;
   logic [31:0] write_data;
   logic        read_valid, read_ack;
   logic [31:0] read_data;
   logic [29:0] wb_adr_o;
   logic [31:0] wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
   logic        bus_err_o, proto_err_o;

   int errors = 0;
   int checks = 0;
   int unsigned cyc_n = 0;

   int          slv_wait = 0;
   bit          slv_dead = 0;
   bit          slv_fixed_en = 0;
   logic [31:0] slv_fixed = 32'd0;

   logic [29:0] log_adr[$];
   logic [31:0] log_dat[$];
   logic [3:0]  log_sel[$];
   logic        log_we[$];
   int unsigned log_start[$];
   int unsigned log_ack[$];

   cpu_wb_bridge #(.TIMEOUT(8), .LINE_WORDS(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
      .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr), .req_we(req_we),
      .write_valid(write_valid), .write_data(write_data), .read_valid(read_valid),
      .read_data(read_data), .read_ack(read_ack), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .bus_err_o(bus_err_o), .proto_err_o(proto_err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Wishbone slave: decides ack 2 time units after each edge.
   initial begin
      int          wcnt;
      int unsigned st;
      wcnt = 0;
      st = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'd0;
      forever begin
         @(posedge clk);
         #2;
         if (wb_cyc_o && wb_stb_o && !slv_dead) begin
            if (wcnt == 0) st = cyc_n;
            if (wcnt == slv_wait) begin
               wb_ack_i = 1'b1;
               wb_dat_i = slv_fixed_en ? slv_fixed : {2'b10, wb_adr_o};
               log_adr.push_back(wb_adr_o);
               log_dat.push_back(wb_we_o ? wb_dat_o : wb_dat_i);
               log_sel.push_back(wb_sel_o);
               log_we.push_back(wb_we_o);
               log_start.push_back(st);
               log_ack.push_back(cyc_n);
               wcnt = 0;
            end else begin
               wb_ack_i = 1'b0;
               wcnt++;
            end
         end else begin
            wb_ack_i = 1'b0;
            wcnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_adr.delete(); log_dat.delete(); log_sel.delete();
      log_we.delete(); log_start.delete(); log_ack.delete();
   endtask

   task automatic post_req(input logic [2:0] len, input logic [3:0] mask,
                           input logic [31:0] addr, input logic we);
      req_len = len; req_mask = mask; req_addr = addr; req_we = we;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic pop_read();
      read_ack = 1'b1;
      tick();
      read_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'd0) begin
         errors++;
         $display("FAIL reset_bus_ctrl: got cyc=%b stb=%b we=%b sel=%h, want all 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o);
      end
      checks++;
      if ({wb_adr_o, wb_dat_o} !== 62'd0) begin
         errors++;
         $display("FAIL reset_bus_data: got adr=%h dat=%h, want 0", wb_adr_o, wb_dat_o);
      end
      checks++;
      if ({read_valid, read_data, bus_err_o, proto_err_o, req_ready} !== 36'd1) begin
         errors++;
         $display("FAIL reset_cpu_side: got rv=%b rd=%h be=%b pe=%b rdy=%b, want 0,0,0,0,1",
                  read_valid, read_data, bus_err_o, proto_err_o, req_ready);
      end
   endtask

   task automatic test_latency();
      slv_wait = 0; slv_fixed_en = 1; slv_fixed = 32'hDEAD_BEEF;
      clear_log();
      post_req(3'd1, 4'hF, 32'h0000_0040, 1'b0);  // returns after edge 1
      tick(); tick();                              // edge 3
      checks++;
      if (read_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: read_valid=%b at cycle 3, want 0", read_valid);
      end
      tick();                                      // edge 4
      checks++;
      if (read_valid !== 1'b1 || read_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL latency_cycle4: read_valid=%b data=%h, want 1 DEADBEEF",
                  read_valid, read_data);
      end
      pop_read();
   endtask

   task automatic test_single_read();
      int n;
      slv_wait = 2; slv_fixed_en = 1; slv_fixed = 32'hCAFE_BABE;
      clear_log();
      post_req(3'd1, 4'b0011, 32'h0000_1002, 1'b0);
      for (n = 0; n < 40 && !read_valid; n++) tick();
      checks++;
      if (log_adr.size() != 1 || log_adr[0] !== 30'h0000_0400 || log_sel[0] !== 4'b0011
          || log_we[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_read_beat: beats=%0d adr=%h sel=%b we=%b, want 1 400 0011 0",
                  log_adr.size(), log_adr[0], log_sel[0], log_we[0]);
      end
      repeat (3) tick();
      checks++;
      if (read_valid !== 1'b1 || read_data !== 32'hCAFE_BABE) begin
         errors++;
         $display("FAIL single_read_hold: rv=%b data=%h, want 1 CAFEBABE", read_valid,
                  read_data);
      end
      pop_read();
      checks++;
      if (read_valid !== 1'b0 || bus_err_o !== 1'b0) begin
         errors++;
         $display("FAIL single_read_pop: rv=%b bus_err=%b, want 0 0", read_valid, bus_err_o);
      end
   endtask

   task automatic test_line_read();
      int n;
      logic [29:0] exp_adr [4];
      exp_adr = '{30'h802, 30'h803, 30'h800, 30'h801};
      slv_wait = 0; slv_fixed_en = 0;
      clear_log();
      post_req(3'd4, 4'h0, 32'h0000_2008, 1'b0);
      for (n = 0; n < 20 && !wb_cyc_o; n++) tick();
      n = 0;
      while (wb_cyc_o && n < 50) begin
         tick();
         n++;
      end
      // Beats at cyc cycles 0,2,4,6; cyc drops on the edge ending cycle 6.
      checks++;
      if (n != 7 || log_adr.size() != 4) begin
         errors++;
         $display("FAIL line_read_cyc: cyc high %0d cycles with %0d beats, want 7 and 4",
                  n, log_adr.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (read_valid !== 1'b1 || read_data !== {2'b10, exp_adr[i]}
             || log_adr[i] !== exp_adr[i] || log_sel[i] !== 4'hF) begin
            errors++;
            $display("FAIL line_read_word%0d: adr=%h sel=%h rv=%b data=%h, want %h F 1 %h",
                     i, log_adr[i], log_sel[i], read_valid, read_data, exp_adr[i],
                     {2'b10, exp_adr[i]});
         end
         pop_read();
      end
      checks++;
      if (read_valid !== 1'b0) begin
         errors++;
         $display("FAIL line_read_drained: read_valid=%b, want 0", read_valid);
      end
   endtask

   task automatic test_line_write();
      int n;
      logic [31:0] wd [4];
      wd = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
      slv_wait = 0; slv_fixed_en = 0;
      clear_log();
      post_req(3'd4, 4'h0, 32'h0000_3000, 1'b1);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL line_write_busy: req_ready=%b while pending, want 0", req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         write_data = wd[i];
         write_valid = 1'b1;
         tick();
         write_valid = 1'b0;
         tick(); tick();
      end
      for (n = 0; n < 30 && (wb_cyc_o || log_adr.size() < 4); n++) tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_dat[i] !== wd[i] || log_adr[i] !== 30'hC00 + 30'(i) || log_sel[i] !== 4'hF
             || log_we[i] !== 1'b1) begin
            errors++;
            $display("FAIL line_write_beat%0d: adr=%h dat=%h sel=%h we=%b, want %h %h F 1",
                     i, log_adr[i], log_dat[i], log_sel[i], log_we[i], 30'hC00 + 30'(i), wd[i]);
         end
      end
      checks++;
      if (req_ready !== 1'b1 || wb_cyc_o !== 1'b0 || log_adr.size() != 4) begin
         errors++;
         $display("FAIL line_write_done: rdy=%b cyc=%b beats=%0d, want 1 0 4", req_ready,
                  wb_cyc_o, log_adr.size());
      end
   endtask

   task automatic test_back_to_back();
      int n;
      slv_wait = 3; slv_fixed_en = 1; slv_fixed = 32'h55AA_55AA;
      clear_log();
      post_req(3'd1, 4'hF, 32'h0000_0100, 1'b1);
      write_data = 32'h0000_0011;
      write_valid = 1'b1;
      tick();
      write_valid = 1'b0;
      post_req(3'd1, 4'hF, 32'h0000_0200, 1'b0);
      for (n = 0; n < 40 && !read_valid; n++) tick();
      checks++;
      if (log_adr.size() != 2 || log_we[0] !== 1'b1 || log_adr[0] !== 30'h40
          || log_dat[0] !== 32'h11) begin
         errors++;
         $display("FAIL b2b_write: beats=%0d we=%b adr=%h dat=%h, want 2 1 040 00000011",
                  log_adr.size(), log_we[0], log_adr[0], log_dat[0]);
      end
      checks++;
      if (log_we[1] !== 1'b0 || log_adr[1] !== 30'h80 || !(log_start[1] > log_ack[0])) begin
         errors++;
         $display("FAIL b2b_read_order: we=%b adr=%h start=%0d write_ack=%0d, want 0 080 start>ack",
                  log_we[1], log_adr[1], log_start[1], log_ack[0]);
      end
      checks++;
      if (read_data !== 32'h55AA_55AA || proto_err_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result: data=%h proto_err=%b, want 55AA55AA 0", read_data,
                  proto_err_o);
      end
      pop_read();
   endtask

   task automatic test_ack_at_timeout();
      int n;
      // Ack arrives in the very cycle the counter reaches TIMEOUT: ack wins.
      slv_wait = 8; slv_fixed_en = 1; slv_fixed = 32'h1234_5678;
      clear_log();
      post_req(3'd1, 4'hF, 32'h0000_0500, 1'b0);
      for (n = 0; n < 40 && !read_valid; n++) tick();
      checks++;
      if (read_valid !== 1'b1 || read_data !== 32'h1234_5678 || bus_err_o !== 1'b0) begin
         errors++;
         $display("FAIL ack_at_timeout: rv=%b data=%h bus_err=%b, want 1 12345678 0",
                  read_valid, read_data, bus_err_o);
      end
      pop_read();
   endtask

   task automatic test_timeout();
      int n;
      slv_dead = 1;
      clear_log();
      post_req(3'd1, 4'hF, 32'h0000_0300, 1'b0);
      for (n = 0; n < 20 && !wb_stb_o; n++) tick();
      n = 0;
      while (wb_stb_o && n < 40) begin
         tick();
         n++;
      end
      // stb stays up while the counter walks 0..8, i.e. TIMEOUT+1 cycles.
      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL timeout_len: stb high %0d cycles, want 9", n);
      end
      checks++;
      if (read_valid !== 1'b1 || read_data !== 32'hFFFF_FFFF || bus_err_o !== 1'b1
          || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_result: rv=%b data=%h bus_err=%b cyc=%b, want 1 FFFFFFFF 1 0",
                  read_valid, read_data, bus_err_o, wb_cyc_o);
      end
      pop_read();
      slv_dead = 0;
   endtask

   task automatic test_overrun_reset();
      int n;
      slv_wait = 1; slv_fixed_en = 0;
      clear_log();
      req_len = 3'd4; req_mask = 4'h0; req_addr = 32'h0000_4000; req_we = 1'b0;
      req_valid = 1'b1;
      tick();
      req_addr = 32'h0000_5000;   // second pulse while the first is still pending
      tick();
      req_valid = 1'b0;
      checks++;
      if (proto_err_o !== 1'b1) begin
         errors++;
         $display("FAIL overrun_proto: proto_err=%b, want 1", proto_err_o);
      end
      for (n = 0; n < 20 && log_adr.size() < 1; n++) tick();
      rst_i = 1'b1;
      tick();
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_burst: cyc=%b stb=%b, want 0 0", wb_cyc_o, wb_stb_o);
      end
      rst_i = 1'b0;
      tick();
      checks++;
      if ({read_valid, req_ready, proto_err_o, bus_err_o} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_flush: rv=%b rdy=%b pe=%b be=%b, want 0 1 0 0", read_valid,
                  req_ready, proto_err_o, bus_err_o);
      end
      n = 0;
      repeat (8) begin
         tick();
         if (wb_cyc_o) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL reset_no_resume: cyc high %0d cycles after reset, want 0", n);
      end
      // Write FIFO overflow with no request behind it.
      for (int i = 0; i < 4; i++) begin
         write_data = 32'h100 + 32'(i);
         write_valid = 1'b1;
         tick();
      end
      write_valid = 1'b0;
      checks++;
      if (proto_err_o !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL wfifo_fill: proto_err=%b rdy=%b, want 0 0", proto_err_o, req_ready);
      end
      write_valid = 1'b1;
      tick();
      write_valid = 1'b0;
      checks++;
      if (proto_err_o !== 1'b1) begin
         errors++;
         $display("FAIL wfifo_overflow: proto_err=%b, want 1", proto_err_o);
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b1 || proto_err_o !== 1'b0) begin
         errors++;
         $display("FAIL wfifo_flush: rdy=%b proto_err=%b, want 1 0", req_ready, proto_err_o);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      req_valid = 1'b0; req_len = 3'd0; req_mask = 4'h0; req_addr = 32'd0; req_we = 1'b0;
      write_valid = 1'b0; write_data = 32'd0; read_ack = 1'b0;
      test_reset();
      test_latency();
      test_single_read();
      test_line_read();
      test_line_write();
      test_back_to_back();
      test_ack_at_timeout();
      test_timeout();
      test_overrun_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
